// File: rtl/clock_phase_checker_if.sv
// Signal bundle between a derived-clock source/observer and clock_phase_checker.
// The master side drives the monitored clock and error clear; the slave side reports.
interface clock_phase_checker_if #(
    parameter int CNT_W = 8
);
    logic             mon_clk;
    logic             clr_err;
    logic             rise_pulse;
    logic             fall_pulse;
    logic             locked;
    logic             err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] meas_high;
    logic [CNT_W-1:0] meas_low;

    modport master (
        output mon_clk, clr_err,
        input  rise_pulse, fall_pulse, locked, err, err_code, meas_high, meas_low
    );

    modport slave (
        input  mon_clk, clr_err,
        output rise_pulse, fall_pulse, locked, err, err_code, meas_high, meas_low
    );
endinterface

// File: rtl/clock_phase_checker.sv
// Samples a derived clock in the master domain, measures high/low runs and tracks lock.
// Define CLKCHK_SYNC_EN to insert a 2-flop synchronizer ahead of the edge detector.
//
// state   | meaning
// ACQUIRE | waiting for first edge; partial run discarded
// TRACK   | comparing completed runs, counting consecutive matches
// LOCKED  | LOCK_RUNS consecutive matches seen; any mismatch is an error
// ERROR   | sticky error held until clr_err
module clock_phase_checker #(
    parameter int EXP_HIGH  = 3,
    parameter int EXP_LOW   = 3,
    parameter int LOCK_RUNS = 8,
    parameter int CNT_W     = 8
) (
    input logic                  clock,
    input logic                  reset,
    clock_phase_checker_if.slave chk
);
    localparam int               GOOD_W    = $clog2(LOCK_RUNS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] EXP_H     = CNT_W'(EXP_HIGH);
    localparam logic [CNT_W-1:0] EXP_L     = CNT_W'(EXP_LOW);
    localparam logic [CNT_W:0]   STUCK_LIM = (CNT_W + 1)'(EXP_HIGH + EXP_LOW);
    localparam logic [GOOD_W-1:0] LOCK_N   = GOOD_W'(LOCK_RUNS);

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        LOCKED  = 2'd2,
        ERROR   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic              mon_in;
    logic              s0, s1;
    logic              rise, fall, edge_det;
    logic              run_ok, stuck;
    logic [CNT_W-1:0]  run_cnt;
    logic [CNT_W-1:0]  meas_high, meas_low;
    logic [GOOD_W-1:0] good_cnt, good_nxt;
    logic [1:0]        err_code, code_nxt;

`ifdef CLKCHK_SYNC_EN
    logic sync_a, sync_b;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= chk.mon_clk;
            sync_b <= sync_a;
        end
    end

    assign mon_in = sync_b;
`else
    assign mon_in = chk.mon_clk;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            s0 <= mon_in;
            s1 <= s0;
        end
    end

    assign rise     = s0 & ~s1;
    assign fall     = ~s0 & s1;
    assign edge_det = rise | fall;

    // run_cnt holds the length of the run that an edge just terminated
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_cnt <= '0;
        end else if (edge_det) begin
            run_cnt <= CNT_W'(1);
        end else if (run_cnt != CNT_MAX) begin
            run_cnt <= run_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meas_high <= '0;
            meas_low  <= '0;
        end else if (state != ACQUIRE) begin
            if (fall) meas_high <= run_cnt;
            if (rise) meas_low  <= run_cnt;
        end
    end

    // a fall completes a high run, a rise completes a low run
    assign run_ok = rise ? (run_cnt == EXP_L) : (run_cnt == EXP_H);
    assign stuck  = {1'b0, run_cnt} > STUCK_LIM;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ACQUIRE;
            good_cnt <= '0;
            err_code <= 2'b00;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            err_code <= code_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        code_nxt  = err_code;
        unique case (state)
            ACQUIRE: begin
                code_nxt = 2'b00;
                if (edge_det) begin
                    state_nxt = TRACK;
                    good_nxt  = '0;
                end
            end
            TRACK: begin
                if (edge_det) begin
                    if (!run_ok) begin
                        good_nxt = '0;
                    end else if (good_cnt == LOCK_N - GOOD_W'(1)) begin
                        state_nxt = LOCKED;
                        good_nxt  = LOCK_N;
                    end else begin
                        good_nxt = good_cnt + GOOD_W'(1);
                    end
                end else if (stuck) begin
                    state_nxt = ERROR;
                    code_nxt  = 2'b11;
                end
            end
            LOCKED: begin
                if (edge_det && !run_ok) begin
                    state_nxt = ERROR;
                    code_nxt  = fall ? 2'b01 : 2'b10;
                end else if (!edge_det && stuck) begin
                    state_nxt = ERROR;
                    code_nxt  = 2'b11;
                end
            end
            ERROR: begin
                if (chk.clr_err) begin
                    state_nxt = ACQUIRE;
                    code_nxt  = 2'b00;
                end
            end
            default: state_nxt = ACQUIRE;
        endcase
    end

    assign chk.rise_pulse = rise;
    assign chk.fall_pulse = fall;
    assign chk.locked     = (state == LOCKED);
    assign chk.err        = (state == ERROR);
    assign chk.err_code   = err_code;
    assign chk.meas_high  = meas_high;
    assign chk.meas_low   = meas_low;
endmodule

// File: tb/tb_clock_phase_checker.sv
// Directed bench for clock_phase_checker: lock, mismatch, stuck, clear, async reset and
// saturation cases with hand-computed expectations.
module tb_clock_phase_checker;
`ifdef CLKCHK_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clock;
    logic reset;
    int   n_vec;
    int   n_err;
    int   ph;

    clock_phase_checker_if #(.CNT_W(8)) cif ();

    clock_phase_checker #(
        .EXP_HIGH (3),
        .EXP_LOW  (3),
        .LOCK_RUNS(8),
        .CNT_W    (8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .chk  (cif)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input logic m);
        cif.mon_clk = m;
        @(posedge clock);
        #1;
    endtask

    task automatic wtick(input int hi, input int lo);
        tick(ph < hi);
        ph = (ph + 1) % (hi + lo);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rise"}, cif.rise_pulse, 0);
        check({tag, "_fall"}, cif.fall_pulse, 0);
        check({tag, "_lock"}, cif.locked, 0);
        check({tag, "_err"},  cif.err, 0);
        check({tag, "_code"}, cif.err_code, 0);
        check({tag, "_mh"},   cif.meas_high, 0);
        check({tag, "_ml"},   cif.meas_low, 0);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        ph          = 0;
        reset       = 1'b0;
        cif.mon_clk = 1'b0;
        cif.clr_err = 1'b0;
        #2;
        check_all_zero("rst0");
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("rst1");
        @(negedge clock);
        reset = 1'b1;

        // clean 3/3: strobes every 3 ticks, lock on the 8th completed run
        repeat (4) tick(1'b0);
        ph = 0;
        for (int i = 1; i <= 26 + LAT; i++) begin
            wtick(3, 3);
            check("s1_rise", cif.rise_pulse, (i > LAT && (i - 1 - LAT) % 6 == 0));
            check("s1_fall", cif.fall_pulse, (i > LAT && (i - 1 - LAT) % 6 == 3));
            check("s1_lock", cif.locked, (i == 26 + LAT));
            if (i == 2 + LAT) check("s1_acq_meas", cif.meas_low, 0);
        end
        check("s1_mh", cif.meas_high, 3);
        check("s1_ml", cif.meas_low, 3);
        check("s1_err", cif.err, 0);

        // one high run stretched to 5
        while (ph != 0) wtick(3, 3);
        repeat (5) tick(1'b1);
        repeat (1 + LAT) tick(1'b0);
        check("s3_fallp", cif.fall_pulse, 1);
        check("s3_lock_hold", cif.locked, 1);
        tick(1'b0);
        check("s3_lock", cif.locked, 0);
        check("s3_err", cif.err, 1);
        check("s3_code", cif.err_code, 1);
        check("s3_mh", cif.meas_high, 5);
        tick(1'b0);
        ph = 0;
        repeat (24) wtick(3, 3);
        check("s3_err_sticky", cif.err, 1);
        check("s3_code_sticky", cif.err_code, 1);
        check("s3_mh_live", cif.meas_high, 3);
        check("s3_ml_live", cif.meas_low, 3);

        // clear in ERROR, then relock
        cif.clr_err = 1'b1;
        wtick(3, 3);
        cif.clr_err = 1'b0;
        check("s5_err", cif.err, 0);
        check("s5_code", cif.err_code, 0);
        check("s5_lock", cif.locked, 0);
        repeat (60) wtick(3, 3);
        check("s5_relock", cif.locked, 1);
        check("s5_relock_err", cif.err, 0);

        // clear while locked is ignored
        cif.clr_err = 1'b1;
        wtick(3, 3);
        cif.clr_err = 1'b0;
        check("s5_clr_lock", cif.locked, 1);
        check("s5_clr_err", cif.err, 0);

        // mon_clk held high: stuck once run_cnt reaches 7
        while (ph != 0) wtick(3, 3);
        for (int t = 1; t <= 9 + LAT; t++) begin
            tick(1'b1);
            if (t == 8 + LAT) begin
                check("s4_pre_lock", cif.locked, 1);
                check("s4_pre_err", cif.err, 0);
            end
        end
        check("s4_err", cif.err, 1);
        check("s4_lock", cif.locked, 0);
        check("s4_code", cif.err_code, 3);
        check("s4_mh", cif.meas_high, 3);

        // long high run saturates the run counter at 255
        repeat (300) tick(1'b1);
        repeat (2 + LAT) tick(1'b0);
        check("sat_mh", cif.meas_high, 255);
        check("sat_code", cif.err_code, 3);

        cif.clr_err = 1'b1;
        tick(1'b0);
        cif.clr_err = 1'b0;
        check("sat_clr_err", cif.err, 0);
        ph = 0;
        repeat (60) wtick(3, 3);
        check("s4_relock", cif.locked, 1);

        // asynchronous reset while locked, away from any clock edge
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("arst");
        @(negedge clock);
        reset = 1'b1;
        ph = 0;
        repeat (60) wtick(3, 3);
        check("arst_relock", cif.locked, 1);
        check("arst_mh", cif.meas_high, 3);

        // 4/2 waveform never locks and never errors
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        ph = 0;
        for (int i = 0; i < 80; i++) begin
            wtick(4, 2);
            check("s2_lock", cif.locked, 0);
            check("s2_err", cif.err, 0);
        end
        check("s2_mh", cif.meas_high, 4);
        check("s2_ml", cif.meas_low, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/clock_phase_checker.md
Name: clock_phase_checker

Overview:
- Consumes one derived clock from the clock generator (processor, imem or regfile clock) and samples it in the master clock domain.
- Produces single-cycle rise/fall strobes for master-domain logic and measures the high and low run lengths.
- Declares lock after consecutive matching runs and flags sticky errors when the waveform deviates from its programmed high/low counts.

Parameters:
EXP_HIGH, 3, expected high run length in master clock cycles (1..2^CNT_W-2)
EXP_LOW, 3, expected low run length in master clock cycles (1..2^CNT_W-2)
LOCK_RUNS, 8, consecutive matching runs (high or low) required for lock
CNT_W, 8, width of run counter and measurement outputs

Ports:
clock  input  1  master clock; the only clock of the block
reset  input  1  asynchronous, active-low reset; clears all state immediately
mon_clk  input  1  derived clock under check; sampled as data on the rising edge of clock
clr_err  input  1  clears sticky error; honoured only in ERROR state
rise_pulse  output  1  one-cycle strobe on detected mon_clk rising edge
fall_pulse  output  1  one-cycle strobe on detected mon_clk falling edge
locked  output  1  waveform matches EXP_HIGH/EXP_LOW
err  output  1  sticky error flag
err_code  output  2  00 none, 01 high mismatch, 10 low mismatch, 11 stuck
meas_high  output  CNT_W  last completed high run length
meas_low  output  CNT_W  last completed low run length

Behaviour:
- Reset (reset=0, async): s0, s1, run_cnt, good_cnt, meas_high, meas_low, err_code = 0; state = ACQUIRE; all outputs 0.
- Sampling: s0 <= mon_clk (or synchronizer output), s1 <= s0. rise = s0 & ~s1; fall = ~s0 & s1; rise_pulse/fall_pulse are driven combinationally from these flops.
  - Latency: the strobe is high in the cycle after the clock edge that first captured the new level.
- Run counter: on rise or fall, run_cnt <= 1; otherwise it increments, saturating at 2^CNT_W-1.
  - On fall, the completed high run = run_cnt; it is loaded into meas_high.
  - On rise, the completed low run = run_cnt; it is loaded into meas_low.
- FSM states: ACQUIRE, TRACK, LOCKED, ERROR.
  - ACQUIRE: waits for the first rise or fall. The first partial run is discarded and is not compared. On that edge: go to TRACK with good_cnt = 0.
  - TRACK: each completed run is compared with the matching expected value.
    - Match: good_cnt++.
    - Mismatch: good_cnt = 0; stay in TRACK.
    - When good_cnt reaches LOCK_RUNS: go to LOCKED and assert locked.
  - LOCKED: a mismatched completed run goes to ERROR.
    - High mismatch: err_code = 01. Low mismatch: err_code = 10.
    - locked drops and err rises in the cycle after the mismatching edge is detected.
  - Stuck detect, in TRACK or LOCKED: when run_cnt exceeds EXP_HIGH+EXP_LOW with no edge, go to ERROR with err_code = 11.
  - ERROR: err = 1, locked = 0; err_code is held. Measurement and strobes continue.
    - clr_err = 1: go to ACQUIRE and clear err_code.
- Boundaries:
  - clr_err in any non-ERROR state: ignored.
  - clr_err together with a new mismatch in ERROR: the clear wins.
  - Saturated run_cnt does not wrap.
  - Edge and stuck in the same cycle: impossible, because an edge resets run_cnt.
  - Reset asserted mid-lock: immediate return to ACQUIRE with all outputs 0.
- Measurements update in every state except ACQUIRE.

Optional Feature:
- Macro: CLKCHK_SYNC_EN.
- Defined: mon_clk passes through a 2-flop synchronizer before s0. Strobes, measurements and errors are delayed 2 extra cycles; run lengths are unchanged. Used when mon_clk comes from a foreign or ~clock-driven generator.
- Undefined: mon_clk feeds s0 directly; latency is as stated in Behaviour.

Test Plan:
- 3-high/3-low mon_clk, defaults -> meas_high = meas_low = 3; locked = 1 after the 8th matching run following the first edge; err = 0; a strobe every 3 cycles, alternating rise/fall.
- 4-high/2-low mon_clk, defaults -> meas_high = 4, meas_low = 2; stays in TRACK; locked = 0 and err = 0 indefinitely.
- Locked, then one high run stretched to 5 -> at fall detection meas_high = 5, locked = 0, err = 1, err_code = 01; err stays set after the waveform returns to 3/3.
- Locked, then mon_clk held high -> run_cnt reaches 7 -> err = 1, err_code = 11; meas_high unchanged.
- In ERROR pulse clr_err -> err = 0, err_code = 00, ACQUIRE; with a clean 3/3 input, locked = 1 again after 8 runs. clr_err pulsed while locked -> no effect.
- reset = 0 asynchronously mid-LOCKED (no clock edge) -> all outputs 0 immediately; relock after release. Repeat the first scenario with CLKCHK_SYNC_EN defined -> strobes 2 cycles later, same lock behaviour.
